// File: rtl/pc_redirect_unit.sv
// PC owner for the MIPS datapath: arbitrates next-PC sources, issues the
// wrong-path flush, link writes, and misaligned register-jump exceptions.
module pc_redirect_unit #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter logic [31:0] EXC_VECTOR = 32'h0000_0080
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic        dec_valid,
    input  logic [31:0] dec_pc,
    input  logic        jr_control,
    input  logic        jalr_control,
    input  logic        jump,
    input  logic        link,
    input  logic [25:0] jump_index,
    input  logic        branch_taken,
    input  logic [15:0] branch_offset,
    input  logic [31:0] rs_data,
    output logic [31:0] pc,
    output logic        flush,
    output logic        link_we,
    output logic        link_sel_ra,
    output logic [31:0] link_addr,
    output logic        exc,
    output logic [31:0] epc
);

    typedef enum logic [1:0] {
        ST_RUN      = 2'd0,
        ST_REDIRECT = 2'd1,
        ST_EXC      = 2'd2
    } state_t;

    state_t      r_state;
    state_t      w_state_nxt;

    logic [31:0] r_pc;
    logic        r_flush;
    logic        r_link_we;
    logic        r_link_sel_ra;
    logic [31:0] r_link_addr;
    logic        r_exc;
    logic [31:0] r_epc;

    logic [31:0] w_pc_nxt;
    logic        w_flush_nxt;
    logic        w_link_we_nxt;
    logic        w_link_sel_ra_nxt;
    logic [31:0] w_link_addr_nxt;
    logic        w_exc_nxt;
    logic [31:0] w_epc_nxt;

    logic        w_accept;
    logic        w_reg_jump;
    logic        w_misalign;
    logic [31:0] w_pc_seq;
    logic [31:0] w_dec_pc4;
    logic [31:0] w_br_off;
    logic [31:0] w_br_tgt;
    logic [31:0] w_j_tgt;

    // Decode is only trusted in RUN; the instruction seen in the
    // post-redirect cycle is the wrong-path fetch being flushed.
    assign w_accept   = !stall && dec_valid && (r_state == ST_RUN);
    assign w_reg_jump = jr_control | jalr_control;
    assign w_misalign = w_reg_jump && (rs_data[1:0] != 2'b00);

    assign w_pc_seq  = r_pc + 32'd4;
    assign w_dec_pc4 = dec_pc + 32'd4;
    assign w_br_off  = {{14{branch_offset[15]}}, branch_offset, 2'b00};
    assign w_br_tgt  = w_dec_pc4 + w_br_off;
    assign w_j_tgt   = {w_dec_pc4[31:28], jump_index, 2'b00};

    always_comb begin
        w_state_nxt       = r_state;
        w_pc_nxt          = r_pc;
        w_flush_nxt       = 1'b0;
        w_link_we_nxt     = 1'b0;
        w_link_sel_ra_nxt = 1'b0;
        w_link_addr_nxt   = r_link_addr;
        w_exc_nxt         = 1'b0;
        w_epc_nxt         = r_epc;

        case (r_state)
            ST_RUN: begin
                if (!stall) begin
                    w_pc_nxt = w_pc_seq;
                end
                if (w_accept) begin
                    if (w_misalign) begin
                        w_pc_nxt    = EXC_VECTOR;
                        w_epc_nxt   = dec_pc;
                        w_flush_nxt = 1'b1;
                        w_exc_nxt   = 1'b1;
                        w_state_nxt = ST_EXC;
                    end else if (w_reg_jump) begin
                        w_pc_nxt    = rs_data;
                        w_flush_nxt = 1'b1;
                        w_state_nxt = ST_REDIRECT;
                        if (jalr_control) begin
                            w_link_we_nxt     = 1'b1;
                            w_link_sel_ra_nxt = 1'b0;
                            w_link_addr_nxt   = w_dec_pc4;
                        end
                    end else if (jump) begin
                        w_pc_nxt    = w_j_tgt;
                        w_flush_nxt = 1'b1;
                        w_state_nxt = ST_REDIRECT;
                        if (link) begin
                            w_link_we_nxt     = 1'b1;
                            w_link_sel_ra_nxt = 1'b1;
                            w_link_addr_nxt   = w_dec_pc4;
                        end
                    end else if (branch_taken) begin
                        w_pc_nxt    = w_br_tgt;
                        w_flush_nxt = 1'b1;
                        w_state_nxt = ST_REDIRECT;
                    end
                end
            end
            ST_REDIRECT, ST_EXC: begin
                // The flush cycle always retires, even under stall.
                w_state_nxt = ST_RUN;
                if (!stall) begin
                    w_pc_nxt = w_pc_seq;
                end
            end
            default: begin
                w_state_nxt = ST_RUN;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state       <= ST_RUN;
            r_pc          <= RESET_PC;
            r_flush       <= 1'b0;
            r_link_we     <= 1'b0;
            r_link_sel_ra <= 1'b0;
            r_link_addr   <= 32'd0;
            r_exc         <= 1'b0;
            r_epc         <= 32'd0;
        end else begin
            r_state       <= w_state_nxt;
            r_pc          <= w_pc_nxt;
            r_flush       <= w_flush_nxt;
            r_link_we     <= w_link_we_nxt;
            r_link_sel_ra <= w_link_sel_ra_nxt;
            r_link_addr   <= w_link_addr_nxt;
            r_exc         <= w_exc_nxt;
            r_epc         <= w_epc_nxt;
        end
    end

    assign pc          = r_pc;
    assign flush       = r_flush;
    assign link_we     = r_link_we;
    assign link_sel_ra = r_link_sel_ra;
    assign link_addr   = r_link_addr;
    assign exc         = r_exc;
    assign epc         = r_epc;

endmodule
